// File: rtl/writeback_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
// Saturation bounds are exported both as default-width constants and as width-generic functions.
package writeback_commit_pkg;

    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned COMMIT_ID_W = 9;

    typedef logic [COMMIT_ID_W-1:0] commit_id_t;

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFault
    } wb_state_e;

    function automatic longint sat_max_of(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min_of(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint sat_max = sat_max_of(DATA_WIDTH);
    localparam longint sat_min = sat_min_of(DATA_WIDTH);

endpackage

// File: rtl/wb_saturate.sv
// Combinational clamp/truncate of a double-width signed result down to data_width.
// Clamping is built only when WRITEBACK_COMMIT_SATURATE_EN is defined; otherwise plain truncation.
module wb_saturate
    import writeback_commit_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic signed [2*data_width-1:0] i_result,
    input  logic                           i_sat_disable,
    output logic signed [data_width-1:0]   o_data,
    output logic                           o_sat
);

`ifdef WRITEBACK_COMMIT_SATURATE_EN
    localparam int unsigned RW = 2 * data_width;
    localparam logic signed [RW-1:0] SatMax = RW'(sat_max_of(data_width));
    localparam logic signed [RW-1:0] SatMin = RW'(sat_min_of(data_width));

    always_comb begin
        o_data = i_result[data_width-1:0];
        o_sat  = 1'b0;
        if (!i_sat_disable) begin
            if (i_result > SatMax) begin
                o_data = SatMax[data_width-1:0];
                o_sat  = 1'b1;
            end else if (i_result < SatMin) begin
                o_data = SatMin[data_width-1:0];
                o_sat  = 1'b1;
            end
        end
    end
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{i_sat_disable, i_result[2*data_width-1:data_width]};
    assign o_data        = i_result[data_width-1:0];
    assign o_sat         = 1'b0;
`endif

endmodule

// File: rtl/writeback_commit.sv
// In-order writeback commit: accepts results whose id matches expected_id, writes one cycle later,
// and faults if a mismatched id stalls too long. Saturation is gated by WRITEBACK_COMMIT_SATURATE_EN.
module writeback_commit
    import writeback_commit_pkg::*;
#(
    parameter int unsigned data_width  = DATA_WIDTH,
    parameter int unsigned n_blocks    = 256,
    parameter int unsigned stall_limit = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   block_in,
    input  logic [3:0]                    dest_in,
    input  logic signed [2*data_width-1:0] result_in,
    input  logic                          saturate_disable_in,
    input  commit_id_t                    commit_id_in,
    input  logic                          commit_flag_in,
    output logic                          wr_en,
    output logic [$clog2(n_blocks)-1:0]   wr_block,
    output logic [3:0]                    wr_addr,
    output logic signed [data_width-1:0]  wr_data,
    output logic                          sat_event,
    output commit_id_t                    expected_id,
    output logic                          fault
);

    localparam int unsigned BlkW = $clog2(n_blocks);
    localparam int unsigned CntW = $clog2(stall_limit + 1);

    wb_state_e                      r_state, w_state_d;
    logic [CntW-1:0]                r_stall_cnt, w_stall_cnt_d;
    commit_id_t                     r_expected_id, w_expected_id_d;
    logic                           r_wr_en, r_sat_event;
    logic [BlkW-1:0]                r_wr_block;
    logic [3:0]                     r_wr_addr;
    logic signed [data_width-1:0]   r_wr_data;

    logic                           w_id_match, w_accept, w_commit, w_mismatch, w_sat;
    logic signed [data_width-1:0]   w_sat_data;

    wb_saturate #(
        .data_width (data_width)
    ) u_wb_saturate (
        .i_result      (result_in),
        .i_sat_disable (saturate_disable_in),
        .o_data        (w_sat_data),
        .o_sat         (w_sat)
    );

    assign w_id_match = (commit_id_in == r_expected_id);
    assign in_ready   = enable && (r_state != StFault) && (!commit_flag_in || w_id_match);
    assign w_accept   = in_valid && in_ready;
    assign w_commit   = w_accept && commit_flag_in;
    assign w_mismatch = enable && in_valid && commit_flag_in && !w_id_match;

    always_comb begin
        w_state_d       = r_state;
        w_stall_cnt_d   = r_stall_cnt;
        w_expected_id_d = r_expected_id;
        if (w_commit) begin
            w_expected_id_d = commit_id_t'(r_expected_id + 1'b1);
        end
        if (enable) begin
            unique case (r_state)
                StRun: begin
                    if (w_mismatch) begin
                        w_state_d = StStall;
                    end
                end
                StStall: begin
                    if (w_accept || !in_valid) begin
                        w_state_d     = StRun;
                        w_stall_cnt_d = '0;
                    end else if (r_stall_cnt == CntW'(stall_limit - 1)) begin
                        w_state_d     = StFault;
                        w_stall_cnt_d = '0;
                    end else begin
                        w_stall_cnt_d = r_stall_cnt + 1'b1;
                    end
                end
                StFault: begin
                    w_state_d = StFault;
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StRun;
            r_stall_cnt   <= '0;
            r_expected_id <= '0;
            r_wr_en       <= 1'b0;
            r_sat_event   <= 1'b0;
            r_wr_block    <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else begin
            r_state       <= w_state_d;
            r_stall_cnt   <= w_stall_cnt_d;
            r_expected_id <= w_expected_id_d;
            // Strobes are single-cycle pulses even if enable drops right after the commit.
            r_wr_en       <= w_commit;
            r_sat_event   <= w_commit && w_sat;
            if (w_commit) begin
                r_wr_block <= block_in;
                r_wr_addr  <= dest_in;
                r_wr_data  <= w_sat_data;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_block    = r_wr_block;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign sat_event   = r_sat_event;
    assign expected_id = r_expected_id;
    assign fault       = (r_state == StFault);

endmodule
